hazard_tracker: RTL

Parametrised hazard and forwarding unit for the pipelined MIPS core. It generalises the fixed E/M/W address/Tnew pipeline to STAGES post-decode slots. It adds stall generation and a multi-cycle mult/div busy tracker. It takes the decoded A1/A2/A3, Tuse and Tnew of the D-stage instruction, and produces the D-stage stall plus a forwarding select for every reading stage.

---
 rtl/hazard_if.sv | 37 +++
 rtl/hazard_tracker.sv | 128 ++++++++++++
 2 files changed

// File: rtl/hazard_if.sv
// Decode-stage hazard query bus. The pipeline side (master) presents the
// decoded D-stage instruction fields; the tracker (slave) answers in the same
// cycle with the stall, the forwarding selects and the mult/div busy flag.
// Timing contract: there is no valid/ready pair. The D fields are sampled every
// cycle. While Stall=1 the master must hold the same D fields so that the
// instruction can be re-presented. The responses are purely combinational from
// the tracker state and the D fields.
interface hazard_if #(
  parameter int STAGES = 3,
  parameter int AW     = 5,
  parameter int TW     = 2,
  parameter int SW     = $clog2(STAGES + 1)
);
  logic [AW-1:0]        D_A1;
  logic [TW-1:0]        D_Tuse1;
  logic [AW-1:0]        D_A2;
  logic [TW-1:0]        D_Tuse2;
  logic [AW-1:0]        D_A3;
  logic [TW-1:0]        D_Tnew;
  logic                 D_IsMD;
  logic                 D_MDOp;
  logic                 D_UseMD;
  logic                 Stall;
  logic [STAGES*SW-1:0] FW1Sel;
  logic [STAGES*SW-1:0] FW2Sel;
  logic                 MDBusy;

  modport master (
    output D_A1, D_Tuse1, D_A2, D_Tuse2, D_A3, D_Tnew, D_IsMD, D_MDOp, D_UseMD,
    input  Stall, FW1Sel, FW2Sel, MDBusy
  );

  modport slave (
    input  D_A1, D_Tuse1, D_A2, D_Tuse2, D_A3, D_Tnew, D_IsMD, D_MDOp, D_UseMD,
    output Stall, FW1Sel, FW2Sel, MDBusy
  );
endinterface

// File: rtl/hazard_tracker.sv
// Hazard and forwarding unit: tracks the register fields of the STAGES
// instructions behind D, raises the D-stage stall for data and HI/LO hazards,
// and selects the forwarding source for every reading stage.
module hazard_tracker #(
  parameter int STAGES   = 3,
  parameter int AW       = 5,
  parameter int TW       = 2,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int SW       = $clog2(STAGES + 1)
) (
  input  logic     clk,
  input  logic     reset,
  hazard_if.slave  bus
);

  localparam int MAXC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  // Slot k (1 = E, 2 = M, ...) holds the instruction k stages behind D.
  logic [AW-1:0] s_a1   [1:STAGES];
  logic [AW-1:0] s_a2   [1:STAGES];
  logic [AW-1:0] s_a3   [1:STAGES];
  logic [TW-1:0] s_tnew [1:STAGES];
  logic          s_md   [1:STAGES];
  logic          s_op   [1:STAGES];
  logic [CW-1:0] md_cnt;

  // Source addresses seen by each reader: reader 0 is D, reader j is slot j.
  logic [AW-1:0] r_a1 [0:STAGES-1];
  logic [AW-1:0] r_a2 [0:STAGES-1];

  logic                 stall;
  logic                 md_busy;
  logic                 dstall1;
  logic                 dstall2;
  logic [SW-1:0]        sel1;
  logic [SW-1:0]        sel2;
  logic [STAGES*SW-1:0] fw1;
  logic [STAGES*SW-1:0] fw2;

  // Advance the slot pipeline (bubble into slot 1 on stall) and run the busy counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 1; k <= STAGES; k++) begin
        s_a1[k]   <= '0;
        s_a2[k]   <= '0;
        s_a3[k]   <= '0;
        s_tnew[k] <= '0;
        s_md[k]   <= 1'b0;
        s_op[k]   <= 1'b0;
      end
      md_cnt <= '0;
    end else begin
      for (int k = STAGES; k >= 2; k--) begin
        s_a1[k]   <= s_a1[k-1];
        s_a2[k]   <= s_a2[k-1];
        s_a3[k]   <= s_a3[k-1];
        s_tnew[k] <= (s_tnew[k-1] != '0) ? s_tnew[k-1] - TW'(1) : '0;
        s_md[k]   <= s_md[k-1];
        s_op[k]   <= s_op[k-1];
      end
      if (stall) begin
        s_a1[1]   <= '0;
        s_a2[1]   <= '0;
        s_a3[1]   <= '0;
        s_tnew[1] <= '0;
        s_md[1]   <= 1'b0;
        s_op[1]   <= 1'b0;
      end else begin
        s_a1[1]   <= bus.D_A1;
        s_a2[1]   <= bus.D_A2;
        s_a3[1]   <= bus.D_A3;
        s_tnew[1] <= bus.D_Tnew;
        s_md[1]   <= bus.D_IsMD;
        s_op[1]   <= bus.D_MDOp;
      end
      if (s_md[1]) begin
        md_cnt <= s_op[1] ? CW'(DIV_CYC) : CW'(MULT_CYC);
      end else if (md_cnt != '0) begin
        md_cnt <= md_cnt - CW'(1);
      end
    end
  end

  // Stall when the youngest producer of a D source is not ready in time, or HI/LO is busy.
  always_comb begin
    dstall1 = 1'b0;
    dstall2 = 1'b0;
    md_busy = (md_cnt != '0) | s_md[1];
    // Scan oldest to youngest so the youngest match decides.
    for (int k = STAGES; k >= 1; k--) begin
      if (bus.D_A1 != '0 && s_a3[k] == bus.D_A1) dstall1 = (s_tnew[k] > bus.D_Tuse1);
      if (bus.D_A2 != '0 && s_a3[k] == bus.D_A2) dstall2 = (s_tnew[k] > bus.D_Tuse2);
    end
    stall = dstall1 | dstall2 | (bus.D_UseMD & md_busy);
  end

  // Forward select per reader: youngest older-slot match, only if its result is ready.
  always_comb begin
    fw1  = '0;
    fw2  = '0;
    sel1 = '0;
    sel2 = '0;
    r_a1[0] = bus.D_A1;
    r_a2[0] = bus.D_A2;
    for (int j = 1; j < STAGES; j++) begin
      r_a1[j] = s_a1[j];
      r_a2[j] = s_a2[j];
    end
    for (int j = 0; j < STAGES; j++) begin
      sel1 = '0;
      sel2 = '0;
      for (int k = STAGES; k > j; k--) begin
        if (r_a1[j] != '0 && s_a3[k] == r_a1[j]) sel1 = (s_tnew[k] == '0) ? SW'(k) : '0;
        if (r_a2[j] != '0 && s_a3[k] == r_a2[j]) sel2 = (s_tnew[k] == '0) ? SW'(k) : '0;
      end
      fw1[j*SW +: SW] = sel1;
      fw2[j*SW +: SW] = sel2;
    end
  end

  assign bus.Stall  = stall;
  assign bus.FW1Sel = fw1;
  assign bus.FW2Sel = fw2;
  assign bus.MDBusy = md_busy;

endmodule
